// File: rtl/cpu_multicycle_pkg.sv
// rtl/cpu_multicycle_pkg.sv - shared opcodes, FSM states and control encodings for the multi-cycle RV32I core
package cpu_multicycle_pkg;

    typedef enum logic [6:0] {
        OP_LW  = 7'b0000011,
        OP_I   = 7'b0010011,
        OP_SW  = 7'b0100011,
        OP_R   = 7'b0110011,
        OP_BEQ = 7'b1100011,
        OP_JAL = 7'b1101111
    } opcode_t;

    typedef enum logic [2:0] {
        START   = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        HALT    = 3'd6
    } mc_state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MDR = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

endpackage

// File: rtl/cpu_multicycle_if.sv
// rtl/cpu_multicycle_if.sv - unified instruction/data memory port with req/ready handshake
interface cpu_multicycle_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit ALU: add, sub, and, or, signed set-less-than
module alu
    import cpu_multicycle_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  ctrl_i,
    output logic [31:0] y_o,
    output logic        zero_o
);
    // Operation select; unknown codes fall back to add
    always_comb begin
        case (ctrl_i)
            ALU_SUB: y_o = a_i - b_i;
            ALU_AND: y_o = a_i & b_i;
            ALU_OR:  y_o = a_i | b_i;
            ALU_SLT: y_o = {31'd0, $signed(a_i) < $signed(b_i)};
            default: y_o = a_i + b_i;
        endcase
    end

    assign zero_o = (y_o == 32'd0);
endmodule

// File: rtl/cpu_multicycle_mc_control.sv
// rtl/cpu_multicycle_mc_control.sv - controller FSM and decode; CPU_MC_ILLEGAL_TRAP_EN makes illegal instructions halt instead of retiring as NOP
module mc_control
    import cpu_multicycle_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       addr_sel_o,
    output logic       ir_we_o,
    output logic       decode_we_o,
    output logic       alu_out_we_o,
    output logic       mdr_we_o,
    output logic       rf_we_o,
    output logic [1:0] wd_sel_o,
    output logic [2:0] alu_ctrl_o,
    output logic       alu_src_imm_o,
    output logic       pc_target_we_o,
    output logic [1:0] imm_sel_o,
    output logic       retired_o,
    output logic       halted_o
);
    localparam logic [2:0] S_START   = START;
    localparam logic [2:0] S_FETCH   = FETCH;
    localparam logic [2:0] S_DECODE  = DECODE;
    localparam logic [2:0] S_EXECUTE = EXECUTE;
    localparam logic [2:0] S_MEM     = MEM;
    localparam logic [2:0] S_WB      = WB;
    localparam logic [2:0] S_HALT    = HALT;

    logic [2:0] state_q, state_d;
    logic       is_r, is_i, is_lw, is_sw, is_beq, is_jal, arith_f3, legal;
    logic [2:0] funct_alu;

    // Classify the instruction held in IR and pick ALU op / immediate format
    always_comb begin
        arith_f3 = funct3_i inside {3'b000, 3'b010, 3'b110, 3'b111};
        is_lw    = (opcode_i == OP_LW)  && (funct3_i == 3'b010);
        is_sw    = (opcode_i == OP_SW)  && (funct3_i == 3'b010);
        is_beq   = (opcode_i == OP_BEQ) && (funct3_i == 3'b000);
        is_jal   = (opcode_i == OP_JAL);
        is_i     = (opcode_i == OP_I) && arith_f3;
        is_r     = (opcode_i == OP_R) && arith_f3 &&
                   ((funct7_i == 7'b0000000) || ((funct7_i == 7'b0100000) && (funct3_i == 3'b000)));
        legal    = is_r | is_i | is_lw | is_sw | is_beq | is_jal;
        case (funct3_i)
            3'b111:  funct_alu = ALU_AND;
            3'b110:  funct_alu = ALU_OR;
            3'b010:  funct_alu = ALU_SLT;
            default: funct_alu = (is_r && funct7_i[5]) ? ALU_SUB : ALU_ADD;
        endcase
        if (is_beq)              alu_ctrl_o = ALU_SUB;
        else if (is_lw || is_sw) alu_ctrl_o = ALU_ADD;
        else                     alu_ctrl_o = funct_alu;
        alu_src_imm_o = is_i | is_lw | is_sw;
        if (is_sw)       imm_sel_o = IMM_S;
        else if (is_beq) imm_sel_o = IMM_B;
        else if (is_jal) imm_sel_o = IMM_J;
        else             imm_sel_o = IMM_I;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_START;
        else          state_q <= state_d;
    end

    // Next state and per-state enables; memory outputs depend only on state and IR
    always_comb begin
        state_d        = state_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        addr_sel_o     = 1'b0;
        ir_we_o        = 1'b0;
        decode_we_o    = 1'b0;
        alu_out_we_o   = 1'b0;
        mdr_we_o       = 1'b0;
        rf_we_o        = 1'b0;
        wd_sel_o       = WD_ALU;
        pc_target_we_o = 1'b0;
        retired_o      = 1'b0;
        halted_o       = 1'b0;
        case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                decode_we_o = 1'b1;
                if (legal) begin
                    state_d = S_EXECUTE;
                end else begin
`ifdef CPU_MC_ILLEGAL_TRAP_EN
                    state_d = S_HALT;
`else
                    retired_o = 1'b1;
                    state_d   = S_FETCH;
`endif
                end
            end
            S_EXECUTE: begin
                if (is_lw || is_sw) begin
                    alu_out_we_o = 1'b1;
                    state_d      = S_MEM;
                end else if (is_beq) begin
                    pc_target_we_o = zero_i;
                    retired_o      = 1'b1;
                    state_d        = S_FETCH;
                end else if (is_jal) begin
                    rf_we_o        = 1'b1;
                    wd_sel_o       = WD_PC;
                    pc_target_we_o = 1'b1;
                    retired_o      = 1'b1;
                    state_d        = S_FETCH;
                end else begin
                    alu_out_we_o = 1'b1;
                    state_d      = S_WB;
                end
            end
            S_MEM: begin
                mem_req_o  = 1'b1;
                mem_we_o   = is_sw;
                addr_sel_o = 1'b1;
                if (mem_ready_i) begin
                    if (is_sw) begin
                        retired_o = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        mdr_we_o = 1'b1;
                        state_d  = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_o   = 1'b1;
                wd_sel_o  = is_lw ? WD_MDR : WD_ALU;
                retired_o = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:  halted_o = 1'b1;
            default: state_d = S_START;
        endcase
    end
endmodule

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, two async read ports, x0 hardwired to zero
module regfile (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we_i,
    input  logic [4:0]  ra1_i,
    input  logic [4:0]  ra2_i,
    input  logic [4:0]  wa_i,
    input  logic [31:0] wd_i,
    output logic [31:0] rd1_o,
    output logic [31:0] rd2_o
);
    logic [31:0] regs_q [32];

    // Clear on reset; writes to x0 are dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regs_q[ra1_i];
    assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regs_q[ra2_i];
endmodule

// File: rtl/sign_extender.sv
// rtl/sign_extender.sv - immediate extraction and sign extension for I/S/B/J formats
module sign_extender
    import cpu_multicycle_pkg::*;
(
    input  logic [31:7] instr_i,
    input  logic [1:0]  sel_i,
    output logic [31:0] imm_o
);
    // Reassemble the scattered immediate bits of the selected format
    always_comb begin
        case (sel_i)
            IMM_S:   imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:   imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_J:   imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
        endcase
    end
endmodule

// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multi-cycle RV32I core datapath (build option CPU_MC_ILLEGAL_TRAP_EN)
module cpu_multicycle
    import cpu_multicycle_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    cpu_multicycle_if.master        mem,
    output logic                    retired,
    output logic                    halted
);
    logic [31:0] pc_q, pc_d, old_pc_q, ir_q, a_q, b_q, alu_out_q, mdr_q, target_q;
    logic [31:0] rd1, rd2, imm_ext, alu_b, alu_y, rf_wd, addr_full;
    logic        alu_zero;
    logic        mem_req_w, mem_we_w, addr_sel, ir_we, decode_we, alu_out_we, mdr_we, rf_we;
    logic        alu_src_imm, pc_target_we;
    logic [1:0]  wd_sel, imm_sel;
    logic [2:0]  alu_ctrl;

    mc_control u_ctrl (
        .clk(clk), .reset_n(reset_n),
        .opcode_i(ir_q[6:0]), .funct3_i(ir_q[14:12]), .funct7_i(ir_q[31:25]),
        .zero_i(alu_zero), .mem_ready_i(mem.mem_ready),
        .mem_req_o(mem_req_w), .mem_we_o(mem_we_w), .addr_sel_o(addr_sel),
        .ir_we_o(ir_we), .decode_we_o(decode_we), .alu_out_we_o(alu_out_we),
        .mdr_we_o(mdr_we), .rf_we_o(rf_we), .wd_sel_o(wd_sel), .alu_ctrl_o(alu_ctrl),
        .alu_src_imm_o(alu_src_imm), .pc_target_we_o(pc_target_we), .imm_sel_o(imm_sel),
        .retired_o(retired), .halted_o(halted)
    );

    regfile u_rf (
        .clk(clk), .reset_n(reset_n), .we_i(rf_we && (ir_q[11:7] != 5'd0)),
        .ra1_i(ir_q[19:15]), .ra2_i(ir_q[24:20]), .wa_i(ir_q[11:7]), .wd_i(rf_wd),
        .rd1_o(rd1), .rd2_o(rd2)
    );

    sign_extender u_sext (.instr_i(ir_q[31:7]), .sel_i(imm_sel), .imm_o(imm_ext));

    assign alu_b = alu_src_imm ? imm_ext : b_q;

    alu u_alu (.a_i(a_q), .b_i(alu_b), .ctrl_i(alu_ctrl), .y_o(alu_y), .zero_o(alu_zero));

    // Next pc: +4 when a fetch completes, branch/jump target when execute redirects
    always_comb begin
        pc_d = pc_q;
        if (ir_we)        pc_d = pc_q + 32'd4;
        if (pc_target_we) pc_d = target_q;
    end

    // Register write-back source: ALU result, loaded word, or link address (pc already old_pc+4)
    always_comb begin
        case (wd_sel)
            WD_MDR:  rf_wd = mdr_q;
            WD_PC:   rf_wd = pc_q;
            default: rf_wd = alu_out_q;
        endcase
    end

    // Datapath registers, each loaded only in the state that owns it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC;
            old_pc_q  <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
            target_q  <= '0;
        end else begin
            pc_q <= pc_d;
            if (ir_we) begin
                ir_q     <= mem.mem_rdata;
                old_pc_q <= pc_q;
            end
            if (decode_we) begin
                a_q      <= rd1;
                b_q      <= rd2;
                target_q <= old_pc_q + imm_ext;
            end
            if (alu_out_we) alu_out_q <= alu_y;
            if (mdr_we)     mdr_q     <= mem.mem_rdata;
        end
    end

    assign addr_full     = addr_sel ? alu_out_q : pc_q;
    assign mem.mem_req   = mem_req_w;
    assign mem.mem_we    = mem_we_w;
    assign mem.mem_addr  = {addr_full[ADDR_W-1:2], 2'b00};
    assign mem.mem_wdata = b_q;
endmodule
